// File: rtl/prbs5_checker.sv
// Receive-side checker for the 5-stage PRBS (s[n] = s[n-2] ^ s[n-5]) test stream.
// Self-synchronises, qualifies lock, counts bit errors and drops lock on error bursts.
module prbs5_checker #(
    parameter int SYNC_LEN   = 8,
    parameter int LOL_THRESH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        din_valid,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    localparam logic [4:0]  SYNC_W   = 5'(SYNC_LEN);
    localparam logic [4:0]  THRESH_W = 5'(LOL_THRESH);
    localparam logic [2:0]  FILL_MAX = 3'd5;
    localparam logic [4:0]  WIN_LAST = 5'd30;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    state_t      state_reg, state_next;
    logic [4:0]  h_reg, h_next;
    logic [2:0]  fill_reg, fill_next;
    logic [4:0]  sync_reg, sync_next;
    logic [4:0]  win_reg, win_next;
    logic [4:0]  werr_reg, werr_next;
    logic        locked_reg, locked_next;
    logic        err_reg, err_next;
    logic [15:0] err_cnt_reg, err_cnt_next;

    logic        pred;
    logic        mismatch;
    logic        count_err;
    logic [4:0]  h_din;
    logic [4:0]  h_pred;
    logic [4:0]  sync_inc;
    logic [4:0]  werr_upd;
    logic [2:0]  fill_inc;

    // h[0] is the newest bit, so h[1] = s[n-2] and h[4] = s[n-5]
    assign pred     = h_reg[1] ^ h_reg[4];
    assign mismatch = din ^ pred;

    assign h_din[0]  = din;
    assign h_pred[0] = pred;
    generate
        for (genvar gi = 1; gi < 5; gi++) begin : g_shift
            assign h_din[gi]  = h_reg[gi-1];
            assign h_pred[gi] = h_reg[gi-1];
        end
    endgenerate

    assign sync_inc  = sync_reg + 5'd1;
    assign werr_upd  = werr_reg + {4'd0, mismatch};
    assign fill_inc  = (fill_reg == FILL_MAX) ? FILL_MAX : fill_reg + 3'd1;
    assign count_err = din_valid && (state_reg == LOCKED) && mismatch;

    always_comb begin
        state_next = state_reg;
        h_next     = h_reg;
        fill_next  = fill_reg;
        sync_next  = sync_reg;
        win_next   = win_reg;
        werr_next  = werr_reg;
        err_next   = 1'b0;
        if (din_valid) begin
            case (state_reg)
                HUNT: begin
                    h_next    = h_din;
                    fill_next = fill_inc;
                    // an all-zero history is never part of a legal stream
                    if (fill_inc == FILL_MAX && h_din != 5'd0) begin
                        state_next = VERIFY;
                        sync_next  = 5'd0;
                    end
                end
                VERIFY: begin
                    h_next = h_din;
                    if (!mismatch) begin
                        sync_next = sync_inc;
                        if (sync_inc == SYNC_W) begin
                            state_next = LOCKED;
                            win_next   = 5'd0;
                            werr_next  = 5'd0;
                        end
                    end else begin
                        state_next = HUNT;
                        sync_next  = 5'd0;
                    end
                end
                LOCKED: begin
                    // free-running reference: a single line error is counted once
                    h_next   = h_pred;
                    err_next = mismatch;
                    if (werr_upd >= THRESH_W) begin
                        state_next = HUNT;
                        h_next     = h_din;
                        fill_next  = FILL_MAX;
                        sync_next  = 5'd0;
                        win_next   = 5'd0;
                        werr_next  = 5'd0;
                    end else if (win_reg == WIN_LAST) begin
                        win_next  = 5'd0;
                        werr_next = 5'd0;
                    end else begin
                        win_next  = win_reg + 5'd1;
                        werr_next = werr_upd;
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
        locked_next = (state_next == LOCKED);
    end

    // a clear that coincides with a counted error leaves that error in the count
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (clr_cnt) begin
            err_cnt_next = {15'd0, count_err};
        end else if (count_err && err_cnt_reg != CNT_MAX) begin
            err_cnt_next = err_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= HUNT;
            h_reg       <= 5'd0;
            fill_reg    <= 3'd0;
            sync_reg    <= 5'd0;
            win_reg     <= 5'd0;
            werr_reg    <= 5'd0;
            locked_reg  <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= 16'd0;
        end else begin
            state_reg   <= state_next;
            h_reg       <= h_next;
            fill_reg    <= fill_next;
            sync_reg    <= sync_next;
            win_reg     <= win_next;
            werr_reg    <= werr_next;
            locked_reg  <= locked_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign locked  = locked_reg;
    assign err     = err_reg;
    assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_prbs5_checker.sv
// Bench for prbs5_checker: directed scenarios plus randomized valid gaps,
// every cycle compared against a queue-based behavioural model.
module tb_prbs5_checker;

    localparam int SYNC_LEN   = 8;
    localparam int LOL_THRESH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;

    prbs5_checker #(.SYNC_LEN(SYNC_LEN), .LOL_THRESH(LOL_THRESH)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .clr_cnt(clr_cnt), .locked(locked), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // one period of the generator sequence, seed 10010
    bit gen [31];
    int pos = 0;

    // behavioural model: hist holds the last five bits, oldest first
    int m_state;        // 0 hunting, 1 verifying, 2 locked
    bit hist [$];
    int m_fill, m_sync, m_win, m_werr, m_cnt;
    bit m_err, m_locked;

    function automatic bit next_bit();
        next_bit = gen[pos % 31];
        pos = pos + 1;
    endfunction

    function automatic void push(bit b);
        hist.push_back(b);
        void'(hist.pop_front());
    endfunction

    function automatic int ones();
        int n = 0;
        foreach (hist[i]) n += int'(hist[i]);
        return n;
    endfunction

    function automatic void model_reset();
        hist.delete();
        repeat (5) hist.push_back(1'b0);
        m_state = 0; m_fill = 0; m_sync = 0; m_win = 0; m_werr = 0;
        m_cnt = 0; m_err = 1'b0; m_locked = 1'b0;
    endfunction

    function automatic void model_step(bit d, bit v, bit c);
        bit p;
        bit miss;
        bit hit = 1'b0;
        m_err = 1'b0;
        if (v) begin
            p = hist[3] ^ hist[0];
            miss = (d != p);
            if (m_state == 0) begin
                push(d);
                if (m_fill < 5) m_fill++;
                if (m_fill == 5 && ones() != 0) begin m_state = 1; m_sync = 0; end
            end else if (m_state == 1) begin
                push(d);
                if (miss) begin
                    m_state = 0; m_sync = 0;
                end else begin
                    m_sync++;
                    if (m_sync == SYNC_LEN) begin m_state = 2; m_win = 0; m_werr = 0; end
                end
            end else begin
                if (miss) begin m_err = 1'b1; hit = 1'b1; m_werr++; end
                if (m_werr >= LOL_THRESH) begin
                    m_state = 0; m_fill = 5; m_sync = 0; push(d);
                end else begin
                    push(p);
                    m_win = (m_win + 1) % 31;
                    if (m_win == 0) m_werr = 0;
                end
            end
        end
        if (c) m_cnt = int'(hit);
        else if (hit && m_cnt < 65535) m_cnt++;
        m_locked = (m_state == 2);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(bit d, bit v, bit c);
        din = d; din_valid = v; clr_cnt = c;
        @(posedge clk);
        model_step(d, v, c);
        #1;
        check("locked", {31'd0, locked}, {31'd0, m_locked});
        check("err", {31'd0, err}, {31'd0, m_err});
        check("err_cnt", {16'd0, err_cnt}, m_cnt);
        @(negedge clk);
    endtask

    task automatic send(bit inv);
        step(next_bit() ^ inv, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr_cnt = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check("rst_locked", {31'd0, locked}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_err_cnt", {16'd0, err_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int lock_at, nvalid;
        bit v;
        gen[0] = 1; gen[1] = 0; gen[2] = 0; gen[3] = 1; gen[4] = 0;
        for (int i = 5; i < 31; i++) gen[i] = gen[i-2] ^ gen[i-5];
        model_reset();
        @(negedge clk);
        do_reset();

        // clean lock after exactly 5 + SYNC_LEN valid bits
        lock_at = 0;
        for (int i = 1; i <= 40 && lock_at == 0; i++) begin
            send(1'b0);
            if (locked) lock_at = i;
        end
        check("clean_lock_bits", lock_at, 5 + SYNC_LEN);
        repeat (310) send(1'b0);
        check("clean_err_cnt", {16'd0, err_cnt}, 0);

        // single error counted once, lock kept
        send(1'b1);
        check("single_err_pulse", {31'd0, err}, 1);
        repeat (31) send(1'b0);
        check("single_err_cnt", {16'd0, err_cnt}, 1);
        check("single_locked", {31'd0, locked}, 1);

        // four errors in one window drop lock
        step(next_bit(), 1'b1, 1'b1);
        for (int i = 0; i < 31 && m_win != 0; i++) send(1'b0);
        send(1'b1); send(1'b0); send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        check("lol_before_4th", {31'd0, locked}, 1);
        send(1'b1);
        check("lol_locked", {31'd0, locked}, 0);
        check("lol_err_cnt", {16'd0, err_cnt}, 4);
        for (int i = 0; i < 80 && !locked; i++) send(1'b0);
        check("relock", {31'd0, locked}, 1);

        // three errors ending one window and one starting the next keep lock
        step(next_bit(), 1'b1, 1'b1);
        for (int i = 0; i < 40 && m_win != 28; i++) send(1'b0);
        send(1'b1); send(1'b1); send(1'b1);
        send(1'b0);
        send(1'b1);
        check("window_locked", {31'd0, locked}, 1);
        check("window_err_cnt", {16'd0, err_cnt}, 4);

        // random valid gaps: lock counts valid bits only
        do_reset();
        nvalid = 0; lock_at = 0;
        for (int i = 0; i < 300 && lock_at == 0; i++) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                nvalid++;
                step(next_bit(), 1'b1, 1'b0);
            end else begin
                step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
            if (locked) lock_at = nvalid;
        end
        check("gap_lock_bits", lock_at, 5 + SYNC_LEN);

        // all-zero stream never leaves hunting
        do_reset();
        repeat (200) step(1'b0, 1'b1, 1'b0);
        check("zero_locked", {31'd0, locked}, 0);

        // counter saturation, clear with coincident error, reset mid-lock
        do_reset();
        repeat (5 + SYNC_LEN) send(1'b0);
        check("edge_locked", {31'd0, locked}, 1);
        force dut.err_cnt_reg = 16'hFFFF;
        #1;
        release dut.err_cnt_reg;
        m_cnt = 65535;
        send(1'b1);
        check("sat_err_cnt", {16'd0, err_cnt}, 32'h0000_FFFF);
        step(next_bit() ^ 1'b1, 1'b1, 1'b1);
        check("clr_with_err", {16'd0, err_cnt}, 1);
        check("clr_locked", {31'd0, locked}, 1);
        din = next_bit(); din_valid = 1'b1;
        do_reset();
        check("rst_mid_locked", {31'd0, locked}, 0);
        check("rst_mid_err_cnt", {16'd0, err_cnt}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
